// File: rtl/trd_sched.sv
// rtl/trd_sched.sv - 8-thread round-robin fetch scheduler with miss blocking.
// Optional watchdog auto-unblock enabled by defining TRD_SCHED_BACKOFF_EN.
module trd_sched #(
    parameter int MISS_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] run_trd,
    input  logic       stall,
    input  logic       i_miss,
    input  logic [2:0] i_miss_trd,
    input  logic       d_miss,
    input  logic [2:0] d_miss_trd,
    input  logic       fill_vld,
    input  logic [2:0] fill_trd,
    input  logic       kill,
    input  logic [2:0] kill_trd,
    output logic [2:0] trd_if,
    output logic       trd_if_vld,
    output logic [7:0] blocked_trd,
    output logic       idle
);

    logic [2:0] last_grant;
    logic [7:0] miss_vec;
    logic [7:0] fill_vec;
    logic [7:0] kill_vec;
    logic [7:0] eligible;
    logic [7:0] expire;
    logic [2:0] winner;
    logic [2:0] idx;
    logic       found;

    always_comb begin
        miss_vec = '0;
        fill_vec = '0;
        kill_vec = '0;
        if (i_miss)   miss_vec[i_miss_trd] = 1'b1;
        if (d_miss)   miss_vec[d_miss_trd] = 1'b1;
        if (fill_vld) fill_vec[fill_trd]   = 1'b1;
        if (kill)     kill_vec[kill_trd]   = 1'b1;
    end

    // A thread missing this very cycle is already ineligible, before its block registers.
    assign eligible = run_trd & ~blocked_trd & ~miss_vec;
    assign idle     = ~|eligible;

    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= 8; k++) begin
            idx = last_grant + 3'(k);
            if (!found && eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trd_if     <= '0;
            trd_if_vld <= 1'b0;
            last_grant <= 3'd7;
        end else if (!stall) begin
            if (found) begin
                trd_if     <= winner;
                trd_if_vld <= 1'b1;
                last_grant <= winner;
            end else begin
                trd_if_vld <= 1'b0;
            end
        end
    end

`ifdef TRD_SCHED_BACKOFF_EN
    logic [7:0] wd_cnt [8];

    // Counter at 1 on a blocked thread means this edge takes it to zero.
    always_comb begin
        expire = '0;
        for (int i = 0; i < 8; i++)
            expire[i] = blocked_trd[i] && (wd_cnt[i] == 8'd1);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (rst || kill_vec[i])
                wd_cnt[i] <= '0;
            else if (miss_vec[i])
                wd_cnt[i] <= 8'(MISS_WAIT);
            else if (fill_vec[i])
                wd_cnt[i] <= '0;
            else if (blocked_trd[i] && wd_cnt[i] != 8'd0)
                wd_cnt[i] <= wd_cnt[i] - 8'd1;
        end
    end
`else
    logic unused_miss_wait;
    assign unused_miss_wait = ^8'(MISS_WAIT);
    assign expire = '0;
`endif

    // Miss beats fill; kill beats both.
    always_ff @(posedge clk) begin
        if (rst)
            blocked_trd <= '0;
        else
            blocked_trd <= ((blocked_trd & ~fill_vec & ~expire) | miss_vec) & ~kill_vec;
    end

endmodule

// File: tb/tb_trd_sched.sv
// tb/tb_trd_sched.sv - self-checking bench for trd_sched against a behavioural model.
module tb_trd_sched;

`ifdef TRD_SCHED_BACKOFF_EN
    localparam bit BACKOFF = 1'b1;
`else
    localparam bit BACKOFF = 1'b0;
`endif
    localparam int WAIT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] run_trd;
    logic       stall;
    logic       i_miss, d_miss, fill_vld, kill;
    logic [2:0] i_miss_trd, d_miss_trd, fill_trd, kill_trd;
    logic [2:0] trd_if;
    logic       trd_if_vld;
    logic [7:0] blocked_trd;
    logic       idle;

    int errors = 0;
    int checks = 0;

    bit m_blk [8];
    int m_cnt [8];
    int m_last;
    int m_trd;
    bit m_vld;
    bit exp_idle;
    bit obs_idle;

    always #5 clk = ~clk;

    trd_sched #(.MISS_WAIT(WAIT)) dut (
        .clk(clk), .rst(rst), .run_trd(run_trd), .stall(stall),
        .i_miss(i_miss), .i_miss_trd(i_miss_trd),
        .d_miss(d_miss), .d_miss_trd(d_miss_trd),
        .fill_vld(fill_vld), .fill_trd(fill_trd),
        .kill(kill), .kill_trd(kill_trd),
        .trd_if(trd_if), .trd_if_vld(trd_if_vld),
        .blocked_trd(blocked_trd), .idle(idle)
    );

    function automatic bit elig(int i);
        return run_trd[i] && !m_blk[i]
            && !(i_miss && int'(i_miss_trd) == i)
            && !(d_miss && int'(d_miss_trd) == i);
    endfunction

    function automatic logic [7:0] m_blk_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_blk[i];
        return v;
    endfunction

    // Advance one clock; the model computes the next state from the rules.
    task automatic cycle();
        bit n_blk [8];
        int n_cnt [8];
        int n_last, n_trd;
        bit n_vld;
        bit mi, fi, ki;
        #1;
        exp_idle = 1'b1;
        for (int i = 0; i < 8; i++) if (elig(i)) exp_idle = 1'b0;
        obs_idle = idle;
        n_blk = m_blk; n_cnt = m_cnt;
        n_last = m_last; n_trd = m_trd; n_vld = m_vld;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin n_blk[i] = 0; n_cnt[i] = 0; end
            n_last = 7; n_trd = 0; n_vld = 0;
        end else begin
            if (!stall) begin
                n_vld = 0;
                for (int k = 1; k <= 8; k++) begin
                    int t;
                    t = (m_last + k) % 8;
                    if (!n_vld && elig(t)) begin
                        n_vld = 1; n_trd = t; n_last = t;
                    end
                end
            end
            for (int i = 0; i < 8; i++) begin
                mi = (i_miss && int'(i_miss_trd) == i) || (d_miss && int'(d_miss_trd) == i);
                fi = fill_vld && int'(fill_trd) == i;
                ki = kill && int'(kill_trd) == i;
                if (ki) begin
                    n_blk[i] = 0; n_cnt[i] = 0;
                end else if (mi) begin
                    n_blk[i] = 1; n_cnt[i] = BACKOFF ? WAIT : 0;
                end else if (fi) begin
                    n_blk[i] = 0; n_cnt[i] = 0;
                end else if (BACKOFF && m_blk[i] && m_cnt[i] > 0) begin
                    n_cnt[i] = m_cnt[i] - 1;
                    if (n_cnt[i] == 0) n_blk[i] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        m_blk = n_blk; m_cnt = n_cnt;
        m_last = n_last; m_trd = n_trd; m_vld = n_vld;
    endtask

    task automatic clear_inputs();
        rst = 0; stall = 0; run_trd = '0;
        i_miss = 0; d_miss = 0; fill_vld = 0; kill = 0;
        i_miss_trd = '0; d_miss_trd = '0; fill_trd = '0; kill_trd = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        run_trd = 8'hFF;
        cycle(); cycle();
        i_miss = 1; i_miss_trd = 3'd6;
        cycle();
        rst = 1; i_miss = 0; fill_vld = 1; fill_trd = 3'd2;
        cycle();
        checks++;
        if (trd_if !== 3'd0 || trd_if_vld !== 1'b0 || blocked_trd !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got trd_if=%0d vld=%b blocked=%h, want 0 0 00", trd_if, trd_if_vld, blocked_trd);
        end
        clear_inputs();
        fill_vld = 1; fill_trd = 3'd5;
        run_trd = 8'hFF;
        cycle();
        checks++;
        if (trd_if !== 3'd0 || trd_if_vld !== 1'b1 || blocked_trd !== 8'h00) begin
            errors++;
            $display("FAIL first_grant: got trd_if=%0d vld=%b blocked=%h, want 0 1 00", trd_if, trd_if_vld, blocked_trd);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        run_trd = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            cycle();
            checks++;
            if (trd_if !== 3'(n % 8) || trd_if_vld !== 1'b1) begin
                errors++;
                $display("FAIL rr_all[%0d]: got trd_if=%0d vld=%b, want %0d 1", n, trd_if, trd_if_vld, n % 8);
            end
        end
    endtask

    task automatic test_sparse();
        int seq [4] = '{2, 5, 7, 2};
        do_reset();
        run_trd = 8'b1010_0100;
        for (int n = 0; n < 4; n++) begin
            cycle();
            checks++;
            if (trd_if !== 3'(seq[n]) || trd_if_vld !== 1'b1) begin
                errors++;
                $display("FAIL rr_sparse[%0d]: got trd_if=%0d vld=%b, want %0d 1", n, trd_if, trd_if_vld, seq[n]);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        run_trd = 8'h10;
        for (int n = 0; n < 4; n++) begin
            cycle();
            checks++;
            if (trd_if !== 3'd4 || trd_if_vld !== 1'b1) begin
                errors++;
                $display("FAIL single[%0d]: got trd_if=%0d vld=%b, want 4 1", n, trd_if, trd_if_vld);
            end
        end
        run_trd = 8'h00;
        cycle();
        checks++;
        if (trd_if_vld !== 1'b0 || trd_if !== 3'd4 || obs_idle !== 1'b1) begin
            errors++;
            $display("FAIL run_drop: got vld=%b trd_if=%0d idle=%b, want 0 4 1", trd_if_vld, trd_if, obs_idle);
        end
    endtask

    task automatic test_dual_miss();
        do_reset();
        run_trd = 8'h28;
        i_miss = 1; i_miss_trd = 3'd3;
        d_miss = 1; d_miss_trd = 3'd5;
        cycle();
        checks++;
        if (obs_idle !== 1'b1 || blocked_trd !== 8'h28 || trd_if_vld !== 1'b0) begin
            errors++;
            $display("FAIL dual_miss: got idle=%b blocked=%h vld=%b, want 1 28 0", obs_idle, blocked_trd, trd_if_vld);
        end
        i_miss = 0; d_miss = 0;
        fill_vld = 1; fill_trd = 3'd3;
        cycle();
        checks++;
        if (obs_idle !== 1'b1 || blocked_trd !== 8'h20) begin
            errors++;
            $display("FAIL fill_clear: got idle=%b blocked=%h, want 1 20", obs_idle, blocked_trd);
        end
        fill_vld = 0;
        cycle();
        checks++;
        if (trd_if !== 3'd3 || trd_if_vld !== 1'b1) begin
            errors++;
            $display("FAIL fill_grant: got trd_if=%0d vld=%b, want 3 1", trd_if, trd_if_vld);
        end
    endtask

    task automatic test_miss_fill_kill();
        do_reset();
        d_miss = 1; d_miss_trd = 3'd4;
        fill_vld = 1; fill_trd = 3'd4;
        cycle();
        checks++;
        if (blocked_trd[4] !== 1'b1) begin
            errors++;
            $display("FAIL miss_beats_fill: got blocked[4]=%b, want 1", blocked_trd[4]);
        end
        d_miss = 0; fill_vld = 0;
        kill = 1; kill_trd = 3'd4;
        cycle();
        checks++;
        if (blocked_trd[4] !== 1'b0) begin
            errors++;
            $display("FAIL kill_clear: got blocked[4]=%b, want 0", blocked_trd[4]);
        end
        i_miss = 1; i_miss_trd = 3'd4;
        cycle();
        checks++;
        if (blocked_trd[4] !== 1'b0) begin
            errors++;
            $display("FAIL kill_beats_miss: got blocked[4]=%b, want 0", blocked_trd[4]);
        end
        kill = 0; i_miss = 0;
    endtask

    task automatic test_stall();
        do_reset();
        run_trd = 8'hFF;
        cycle(); cycle(); cycle();
        stall = 1;
        for (int n = 0; n < 3; n++) begin
            cycle();
            checks++;
            if (trd_if !== 3'd2 || trd_if_vld !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got trd_if=%0d vld=%b, want 2 1", n, trd_if, trd_if_vld);
            end
        end
        stall = 0;
        cycle();
        checks++;
        if (trd_if !== 3'd3 || trd_if_vld !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got trd_if=%0d vld=%b, want 3 1", trd_if, trd_if_vld);
        end
    endtask

    task automatic test_backoff();
        bit want;
        do_reset();
        run_trd = 8'h02;
        i_miss = 1; i_miss_trd = 3'd1;
        cycle();
        i_miss = 0;
        for (int c = 0; c < 12; c++) begin
            want = BACKOFF ? (c < WAIT) : 1'b1;
            checks++;
            if (blocked_trd[1] !== want) begin
                errors++;
                $display("FAIL backoff[%0d]: got blocked[1]=%b, want %b", c, blocked_trd[1], want);
            end
            cycle();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(63) == 0);
            stall      = ($urandom_range(4) == 0);
            run_trd    = 8'($urandom) | 8'($urandom);
            i_miss     = ($urandom_range(3) == 0);
            d_miss     = ($urandom_range(3) == 0);
            fill_vld   = ($urandom_range(2) == 0);
            kill       = ($urandom_range(9) == 0);
            i_miss_trd = 3'($urandom);
            d_miss_trd = 3'($urandom);
            fill_trd   = 3'($urandom);
            kill_trd   = 3'($urandom);
            cycle();
            checks++;
            if (obs_idle !== exp_idle || trd_if_vld !== m_vld || trd_if !== 3'(m_trd)
                || blocked_trd !== m_blk_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got idle=%b vld=%b trd_if=%0d blocked=%h, want %b %b %0d %h",
                         n, obs_idle, trd_if_vld, trd_if, blocked_trd, exp_idle, m_vld, m_trd, m_blk_vec());
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        for (int i = 0; i < 8; i++) begin m_blk[i] = 0; m_cnt[i] = 0; end
        m_last = 7; m_trd = 0; m_vld = 0;
        test_reset();
        test_round_robin();
        test_sparse();
        test_single();
        test_dual_miss();
        test_miss_fill_kill();
        test_stall();
        test_backoff();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
